// File: rtl/stage_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode slot.
// master = fetch stage, slave = memory/decode side.
interface stage_fetch_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            de_stall;
  logic            de_setpc;
  logic [XLEN-1:0] de_newpc;
  logic            ex_br_miss;

  logic            de_valid;
  logic [XLEN-1:0] de_insn;
  logic [XLEN-1:0] de_pc;
  logic            fetch_fault;

  modport master (
    output imem_req, imem_addr, de_valid, de_insn, de_pc, fetch_fault,
    input  imem_ready, imem_rvalid, imem_rdata, de_stall, de_setpc, de_newpc, ex_br_miss
  );

  modport slave (
    input  imem_req, imem_addr, de_valid, de_insn, de_pc, fetch_fault,
    output imem_ready, imem_rvalid, imem_rdata, de_stall, de_setpc, de_newpc, ex_br_miss
  );
endinterface

// File: rtl/stage_fetch.sv
// Instruction fetch stage: owns the PC, keeps up to 2 requests outstanding, buffers responses.
// Optional FETCH_ALIGN_TRAP_EN: misaligned redirect halts fetch and raises fetch_fault.
module stage_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  stage_fetch_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] drop_cnt;
  logic [XLEN-1:0]  pcq [2];
  logic             pcq_rd;
  logic [XLEN-1:0]  buf_insn [2];
  logic [XLEN-1:0]  buf_pc [2];
  logic             buf_rd;
  logic             fault;
  logic             de_valid_q;
  logic [XLEN-1:0]  de_insn_q;
  logic [XLEN-1:0]  de_pc_q;

  logic             req;
  logic             accept;
  logic             rsp;
  logic [XLEN-1:0]  rsp_pc;
  logic             flush;
  logic             consume;
  logic             slot_free;
  logic             drop;
  logic             keep;
  logic             refill;
  logic             bypass;
  logic             push;
  logic [CNT_W-1:0] inflight_nxt;
  logic [CNT_W-1:0] buf_count_nxt;
  logic [XLEN-1:0]  redirect_pc;
  logic             fault_nxt;

  // Request is a function of registered state only.
  assign req           = ~fault & ((3'(inflight) + 3'(buf_count)) < 3'd2);
  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.de_valid  = de_valid_q;
  assign bus.de_insn   = de_insn_q;
  assign bus.de_pc     = de_pc_q;

  always_comb begin
    accept        = req & bus.imem_ready;
    rsp           = bus.imem_rvalid & (inflight != 2'd0);
    rsp_pc        = pcq[pcq_rd];
    flush         = bus.ex_br_miss | (bus.de_setpc & ~bus.de_stall);
    consume       = de_valid_q & ~bus.de_stall;
    slot_free     = ~de_valid_q | consume;
    drop          = rsp & (drop_cnt != 2'd0);
    keep          = rsp & ~drop & ~flush;
    refill        = slot_free & (buf_count != 2'd0) & ~flush;
    bypass        = keep & (buf_count == 2'd0) & slot_free;
    push          = keep & ~bypass;
    inflight_nxt  = inflight + CNT_W'(accept) - CNT_W'(rsp);
    buf_count_nxt = buf_count + CNT_W'(push) - CNT_W'(refill);
`ifdef FETCH_ALIGN_TRAP_EN
    redirect_pc   = bus.de_newpc;
    fault_nxt     = flush ? (bus.de_newpc[1:0] != 2'b00) : fault;
`else
    redirect_pc   = bus.de_newpc & ~32'h3;
    fault_nxt     = 1'b0;
`endif
  end

  // PC, outstanding-request tracking and stale-response accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      pcq_rd   <= 1'b0;
      pcq[0]   <= '0;
      pcq[1]   <= '0;
      fault    <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      fault    <= fault_nxt;
      if (accept) pcq[pcq_rd ^ inflight[0]] <= pc;
      if (rsp) pcq_rd <= ~pcq_rd;
      if (flush) begin
        pc       <= redirect_pc;
        drop_cnt <= inflight_nxt;
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (drop) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  // Response buffer; cleared on flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_count   <= '0;
      buf_rd      <= 1'b0;
      buf_insn[0] <= '0;
      buf_insn[1] <= '0;
      buf_pc[0]   <= '0;
      buf_pc[1]   <= '0;
    end else if (flush) begin
      buf_count <= '0;
    end else begin
      buf_count <= buf_count_nxt;
      if (push) begin
        buf_insn[buf_rd ^ buf_count[0]] <= bus.imem_rdata;
        buf_pc[buf_rd ^ buf_count[0]]   <= rsp_pc;
      end
      if (refill) buf_rd <= ~buf_rd;
    end
  end

  // Decode slot: buffer head wins over a bypassed response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_valid_q <= 1'b0;
      de_insn_q  <= '0;
      de_pc_q    <= '0;
    end else if (flush) begin
      de_valid_q <= 1'b0;
    end else if (refill) begin
      de_valid_q <= 1'b1;
      de_insn_q  <= buf_insn[buf_rd];
      de_pc_q    <= buf_pc[buf_rd];
    end else if (bypass) begin
      de_valid_q <= 1'b1;
      de_insn_q  <= bus.imem_rdata;
      de_pc_q    <= rsp_pc;
    end else if (consume) begin
      de_valid_q <= 1'b0;
    end
  end

`ifdef FETCH_ALIGN_TRAP_EN
  assign bus.fetch_fault = fault;
`else
  assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_stage_fetch.sv
// Randomized bench for stage_fetch: in-order memory model plus an instruction-stream scoreboard.
module tb_stage_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stage_fetch_if bus ();
  stage_fetch #(.RESET_PC(RESET_PC)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int consumed = 0;
  int first_acc   = -1;
  int first_valid = -1;
  bit stream_phase = 1'b0;

  logic [31:0] mem_addr_q [$];
  int          mem_time_q [$];
  logic [31:0] exp_pc;
  logic [31:0] fetch_exp;
  logic        exp_fault;
  logic        hold_pending;
  logic [31:0] hold_pc;
  logic [31:0] hold_insn;
  logic        flush_prev;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  // mode 0: ideal 1-cycle memory, no stall; 1: random; 2: memory silent, no stall.
  task automatic do_cycle(input int mode, input bit f_en, input bit f_stall,
                          input bit f_setpc, input bit f_brmiss, input logic [31:0] f_target);
    logic flush, accept, rv;
    @(negedge clk);
    bus.de_stall   = 1'b0;
    bus.de_setpc   = 1'b0;
    bus.ex_br_miss = 1'b0;
    bus.imem_ready = 1'b1;
    bus.de_newpc   = $urandom;
    if (mode == 1) begin
      bus.de_stall   = ($urandom % 4) == 0;
      bus.imem_ready = ($urandom % 4) != 0;
      bus.de_setpc   = ($urandom % 20) == 0;
      bus.ex_br_miss = ($urandom % 40) == 0;
`ifdef FETCH_ALIGN_TRAP_EN
      bus.de_newpc   = $urandom & 32'h0000_0FFC;
`else
      bus.de_newpc   = $urandom & 32'h0000_0FFF;
`endif
    end
    if (f_en) begin
      bus.de_stall   = f_stall;
      bus.de_setpc   = f_setpc;
      bus.ex_br_miss = f_brmiss;
      bus.de_newpc   = f_target;
    end
    rv = (mem_addr_q.size() != 0) && (mem_time_q[0] <= cyc) && (mode != 2);
    if (mode == 1 && rv) rv = ($urandom % 3) != 0;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? insn_of(mem_addr_q[0]) : $urandom;
    #1;

    flush  = bus.ex_br_miss | (bus.de_setpc & ~bus.de_stall);
    accept = bus.imem_req & bus.imem_ready;

    check("fault", 32'(bus.fetch_fault), 32'(exp_fault));
    if (exp_fault) begin
      check("req_halted", 32'(bus.imem_req), 32'd0);
      check("valid_halted", 32'(bus.de_valid), 32'd0);
    end
    if (cyc == 0) check("first_req", 32'(bus.imem_req), 32'd1);
    if (bus.imem_req) check("imem_addr", bus.imem_addr, fetch_exp);
    if (hold_pending) begin
      check("hold_valid", 32'(bus.de_valid), 32'd1);
      check("hold_pc", bus.de_pc, hold_pc);
      check("hold_insn", bus.de_insn, hold_insn);
    end
    if (flush_prev) check("flush_clears_slot", 32'(bus.de_valid), 32'd0);
    if (stream_phase && cyc >= 2) check("stream_valid", 32'(bus.de_valid), 32'd1);
    if (bus.de_valid && first_valid < 0) first_valid = cyc;

    if (bus.de_valid && !bus.de_stall) begin
      check("de_pc", bus.de_pc, exp_pc);
      check("de_insn", bus.de_insn, insn_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (accept) begin
      if (first_acc < 0) first_acc = cyc;
      mem_addr_q.push_back(bus.imem_addr);
      mem_time_q.push_back(cyc + 1 + ((mode == 1) ? int'($urandom % 3) : 0));
      fetch_exp = fetch_exp + 32'd4;
    end
    if (rv) begin
      void'(mem_addr_q.pop_front());
      void'(mem_time_q.pop_front());
    end
    if (flush) begin
`ifdef FETCH_ALIGN_TRAP_EN
      exp_fault = bus.de_newpc[1:0] != 2'b00;
      fetch_exp = bus.de_newpc;
`else
      fetch_exp = {bus.de_newpc[31:2], 2'b00};
`endif
      exp_pc = fetch_exp;
    end
    hold_pending = bus.de_valid & bus.de_stall & ~flush;
    hold_pc      = bus.de_pc;
    hold_insn    = bus.de_insn;
    flush_prev   = flush;
    cyc++;
  endtask

  task automatic run(input int mode, input int n);
    for (int i = 0; i < n; i++) do_cycle(mode, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic redirect(input bit stall, input bit setpc, input bit brmiss, input logic [31:0] t);
    do_cycle(0, 1'b1, stall, setpc, brmiss, t);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.de_stall    = 1'b0;
    bus.de_setpc    = 1'b0;
    bus.de_newpc    = '0;
    bus.ex_br_miss  = 1'b0;
    exp_pc       = RESET_PC;
    fetch_exp    = RESET_PC;
    exp_fault    = 1'b0;
    hold_pending = 1'b0;
    hold_pc      = '0;
    hold_insn    = '0;
    flush_prev   = 1'b0;
    #23;
    check("rst_de_valid", 32'(bus.de_valid), 32'd0);
    check("rst_de_insn", bus.de_insn, 32'd0);
    check("rst_de_pc", bus.de_pc, 32'd0);
    check("rst_fault", 32'(bus.fetch_fault), 32'd0);
    check("rst_pc", bus.imem_addr, RESET_PC);
    @(posedge clk);
    #2 reset_n = 1'b1;

    stream_phase = 1'b1;
    run(0, 20);
    stream_phase = 1'b0;
    check("first_latency", 32'(first_valid - first_acc), 32'd2);

    run(1, 3000);
    run(0, 10);

    // two requests in flight, then decode redirect
    run(2, 2);
    redirect(1'b0, 1'b1, 1'b0, 32'h0000_0200);
    run(0, 10);
    // redirect while stalled is ignored
    redirect(1'b1, 1'b1, 1'b0, 32'h0000_0600);
    run(0, 6);
    // mispredict while stalled
    redirect(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    run(0, 8);
    // PC wraps modulo 2^32
    redirect(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
    run(0, 8);
    // misaligned target
    redirect(1'b0, 1'b1, 1'b0, 32'h0000_0202);
    run(0, 8);
`ifdef FETCH_ALIGN_TRAP_EN
    redirect(1'b0, 1'b1, 1'b0, 32'h0000_0300);
    run(0, 8);
`endif
    check("progress", 32'(consumed > 400), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction fetch stage. Sits between instruction memory and `stage_decode`. It owns the program counter and issues in-order word requests to instruction memory, with up to 2 outstanding. Returned words are buffered and presented to decode as `de_valid`/`de_insn`/`de_pc`. On a redirect from decode or execute it flushes all younger state and discards stale responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word address of the request.
- `imem_ready` in 1: request accepted when `imem_req & imem_ready`.
- `imem_rvalid` in 1: response valid. Responses return in order, minimum 1 cycle after acceptance.
- `imem_rdata` in 32: response word.
- `de_stall` in 1: decode cannot consume this cycle.
- `de_setpc` in 1: redirect request.
- `de_newpc` in 32: redirect target.
- `ex_br_miss` in 1: execute mispredict. The current decode slot is wrong-path.
- `de_valid` out 1: decode slot holds an instruction.
- `de_insn` out 32: instruction.
- `de_pc` out 32: its address.
- `fetch_fault` out 1: misaligned redirect target, fetch halted (see Configuration).

## Operation
- **Consume:** the decode slot is consumed when `de_valid & ~de_stall`.
- **Flush condition:** `flush = ex_br_miss | (de_setpc & ~de_stall)`.
- **Redirect while stalled:** `de_setpc & de_stall & ~ex_br_miss` is ignored. Decode re-asserts the redirect when it unstalls.
- **Request side:**
  - `imem_addr = pc`.
  - `imem_req = ~fetch_fault & (inflight + buf_count < 2)`.
  - `inflight` (0..2) counts accepted requests without a response. This includes requests marked for drop.
  - `buf_count` (0..2) counts entries in the response FIFO.
  - On acceptance: `pc <= pc + 4`, and the request's PC is pushed into a 2-entry PC FIFO.
  - `imem_req` has no combinational dependence on `de_setpc`/`ex_br_miss`/`de_stall`.
  - An unaccepted request may change address on the next cycle after a flush.
- **Response side:**
  - Each `imem_rvalid` pops the PC FIFO.
  - If `drop_cnt > 0`: the response is discarded and `drop_cnt` decrements.
  - Otherwise `{imem_rdata, pc}` is handled as follows:
    - Written directly into the decode slot if the buffer is empty and the slot is empty or being consumed (bypass).
    - Else pushed into the 2-entry buffer.
- **Slot refill:** when the slot is empty or consumed and the buffer is non-empty, the head loads into the slot. The buffer head has priority over the bypass.
- **Flush actions, at the edge ending the flush cycle:**
  - `pc <= de_newpc`.
  - Buffer cleared; decode slot cleared (`de_valid <= 0`).
  - `drop_cnt <= inflight_next`, i.e. the in-flight count after this cycle's accept and return.
  - A request accepted in the flush cycle is counted as stale.
  - A response arriving in the flush cycle is discarded.
- **Capacity invariant:** `inflight + buf_count <= 2`. The buffer never overflows.
- **Width rule:** PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- **Reset values:**
  - `de_valid=0`, `de_insn=0`, `de_pc=0`, `fetch_fault=0`.
  - `pc=RESET_PC`.
  - All counts 0; FIFOs empty.
- **First request:** `imem_req=1` in the first cycle after reset deassertion.
- **Latency:** request accepted in cycle N, response in cycle R ≥ N+1. Then:
  - `de_valid=1` in cycle R+1 via bypass.
  - Otherwise no earlier than R+2.
- **Throughput:** with `imem_ready=1`, 1-cycle memory and no stall, one instruction per cycle in steady state.
- **Redirect:** flush in cycle F means `imem_addr=de_newpc` in cycle F+1. The first new instruction is valid no earlier than F+3 with 1-cycle memory.
- **Reset mid-operation:** all state returns to reset values asynchronously. Responses arriving after reset release are not expected (memory resets too).

## Configuration
- Macro: `FETCH_ALIGN_TRAP_EN`.
- **Defined:**
  - A flush with `de_newpc[1:0] != 0` sets `fetch_fault=1` at the flush edge.
  - `imem_req` is held 0 while faulted; stale responses are still dropped.
  - `de_valid` stays 0.
  - The fault clears on the next flush with an aligned target, which resumes fetch there.
- **Undefined:**
  - `fetch_fault` tied 0.
  - `pc[1:0]` is forced to 0 on redirect (target 0x202 fetches 0x200).

## Test plan
- **Reset and stream:** `RESET_PC=0x100`, 1-cycle memory, no stall -> addresses 0x100, 0x104, 0x108… One instruction per cycle; `de_pc` sequential; first `de_valid` 2 cycles after first accept.
- **Stall:** `de_stall` held 3 cycles mid-stream -> `de_insn`/`de_pc` constant; `imem_req=0` once `inflight+buf_count=2`; no instruction lost or duplicated after release.
- **Decode redirect:** `de_setpc=1, de_stall=0, de_newpc=0x200` with 2 requests in flight -> both responses discarded; next `de_valid` shows `de_pc=0x200`, then 0x204.
- **Redirect while stalled:** `de_setpc=1, de_stall=1, ex_br_miss=0` -> ignored; slot held; `pc` unchanged.
- **Mispredict while stalled:** `ex_br_miss=1` with `de_stall=1`, target 0x400 -> `de_valid=0` next cycle; `imem_addr=0x400` next cycle.
- **Misaligned target:** `de_newpc=0x202`.
  - With macro: `fetch_fault=1`, `imem_req=0`; a later redirect to 0x300 clears the fault and fetches 0x300.
  - Without macro: fetch proceeds at 0x200.
